// File: rtl/conv2_filter_seq_pkg.sv
// Shared types for the conv2 filter sequencer: FSM state encoding, default tap count,
// and the index-width helper.
package conv2_filter_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLR   = 3'd2,
    S_MAC   = 3'd3,
    S_DRAIN = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  localparam int TAPS_DEF = 9;
  localparam int CNT_W    = 4;

  // Index widths never drop below 1 bit, so a single-entry dimension still has a port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv2_filter_seq_if.sv
// Control, datapath-drive and writeback handshake bundle of the conv2 sequencer.
// The master side is the sequencer; the slave side is the CPU/datapath/writeback.
interface conv2_filter_seq_if #(
  parameter int ROW_W  = 3,
  parameter int COL_W  = 3,
  parameter int FILT_W = 4
);
  import conv2_filter_seq_pkg::*;

  logic              start;
  logic [1:0]        cfg_sel;
  logic              cfg_gate;
  logic              busy;
  logic              done;
  logic              fetch_req;
  logic [ROW_W-1:0]  fetch_row;
  logic [COL_W-1:0]  fetch_col;
  logic [FILT_W-1:0] fetch_filt;
  logic              acc_reset;
  logic              WE;
  logic [CNT_W-1:0]  counter;
  logic [1:0]        sel;
  logic              and_control;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  start, cfg_sel, cfg_gate, out_ready,
    output busy, done, fetch_req, fetch_row, fetch_col, fetch_filt,
           acc_reset, WE, counter, sel, and_control, out_valid
  );

  modport slave (
    output start, cfg_sel, cfg_gate, out_ready,
    input  busy, done, fetch_req, fetch_row, fetch_col, fetch_filt,
           acc_reset, WE, counter, sel, and_control, out_valid
  );

endinterface

// File: rtl/conv2_pix_counter.sv
// Output-pixel index chain: col wraps into row, row wraps into filt; one step per advance.
// Registered indices, sync clear; last flags the final (row, col, filt) of the layer.
module conv2_pix_counter
  import conv2_filter_seq_pkg::*;
#(
  parameter int OUT_W  = 8,
  parameter int OUT_H  = 8,
  parameter int N_FILT = 16,
  parameter int COL_W  = idx_w(OUT_W),
  parameter int ROW_W  = idx_w(OUT_H),
  parameter int FILT_W = idx_w(N_FILT)
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic [FILT_W-1:0] filt,
  output logic              last
);

  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(OUT_W - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(OUT_H - 1);
  localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(N_FILT - 1);

  logic col_end, row_end, filt_end;

  assign col_end  = (col == COL_MAX);
  assign row_end  = (row == ROW_MAX);
  assign filt_end = (filt == FILT_MAX);
  assign last     = col_end && row_end && filt_end;

  always_ff @(posedge clk_i) begin
    if (rst || clear) begin
      row  <= '0;
      col  <= '0;
      filt <= '0;
    end else if (advance) begin
      if (!col_end) begin
        col <= col + 1'b1;
      end else begin
        col <= '0;
        if (!row_end) begin
          row <= row + 1'b1;
        end else begin
          row  <= '0;
          filt <= filt_end ? '0 : filt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/conv2_filter_seq.sv
// Conv2 sequencer: per pixel LOAD(FETCH_LAT) CLR(1) MAC(TAPS) DRAIN(PIPE_LAT) OUT(>=1) cycles.
// All outputs registered; OUT holds out_valid and the tag until out_ready, issuing nothing else.
module conv2_filter_seq
  import conv2_filter_seq_pkg::*;
#(
  parameter int OUT_W     = 8,
  parameter int OUT_H     = 8,
  parameter int N_FILT    = 16,
  parameter int TAPS      = TAPS_DEF,
  parameter int FETCH_LAT = 1,
  parameter int PIPE_LAT  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst,
  conv2_filter_seq_if.master    bus
);

  localparam int PH_W = 8;

  state_t          state;
  logic [PH_W-1:0] phase;
  logic            cfg_gate_q;
  logic            pix_clear;
  logic            pix_adv;
  logic            pix_last;

  // A start landing on the done cycle belongs to the layer just finishing and is dropped.
  assign pix_clear = (state == S_IDLE) && bus.start && !bus.done;
  assign pix_adv   = (state == S_OUT) && bus.out_ready;

  conv2_pix_counter #(
    .OUT_W  (OUT_W),
    .OUT_H  (OUT_H),
    .N_FILT (N_FILT),
    .COL_W  ($bits(bus.fetch_col)),
    .ROW_W  ($bits(bus.fetch_row)),
    .FILT_W ($bits(bus.fetch_filt))
  ) u_pix (
    .clk_i   (clk_i),
    .rst     (rst),
    .clear   (pix_clear),
    .advance (pix_adv),
    .row     (bus.fetch_row),
    .col     (bus.fetch_col),
    .filt    (bus.fetch_filt),
    .last    (pix_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state           <= S_IDLE;
      phase           <= '0;
      cfg_gate_q      <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.fetch_req   <= 1'b0;
      bus.acc_reset   <= 1'b0;
      bus.WE          <= 1'b0;
      bus.counter     <= '0;
      bus.sel         <= 2'b00;
      bus.and_control <= 1'b0;
      bus.out_valid   <= 1'b0;
    end else begin
      bus.done      <= 1'b0;
      bus.fetch_req <= 1'b0;
      bus.acc_reset <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pix_clear) begin
            bus.sel       <= bus.cfg_sel;
            cfg_gate_q    <= bus.cfg_gate;
            bus.busy      <= 1'b1;
            bus.fetch_req <= 1'b1;
            phase         <= PH_W'(FETCH_LAT - 1);
            state         <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (phase == '0) begin
            bus.acc_reset <= 1'b1;
            state         <= S_CLR;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        S_CLR: begin
          bus.WE          <= 1'b1;
          bus.counter     <= '0;
          bus.and_control <= cfg_gate_q;
          phase           <= PH_W'(TAPS - 1);
          state           <= S_MAC;
        end
        S_MAC: begin
          // counter is left at TAPS-1 once the window is consumed
          if (phase == '0) begin
            bus.WE          <= 1'b0;
            bus.and_control <= 1'b0;
            phase           <= PH_W'(PIPE_LAT - 1);
            state           <= S_DRAIN;
          end else begin
            phase       <= phase - 1'b1;
            bus.counter <= bus.counter + 1'b1;
          end
        end
        S_DRAIN: begin
          if (phase == '0) begin
            bus.out_valid <= 1'b1;
            state         <= S_OUT;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (pix_last) begin
              bus.busy    <= 1'b0;
              bus.done    <= 1'b1;
              bus.counter <= '0;
              state       <= S_IDLE;
            end else begin
              bus.fetch_req <= 1'b1;
              phase         <= PH_W'(FETCH_LAT - 1);
              state         <= S_LOAD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
